// File: rtl/wptr_full_ctrl.sv
// rtl/wptr_full_ctrl.sv - async FIFO write-side pointer, full/almost-full and level generator
//
// Purpose: keeps the binary/Gray write pointer, compares it with the
// synchronized Gray read pointer and registers full, almost-full, fill level
// and (optionally) a sticky overflow flag.
// Optional feature macro: WFULL_OVERFLOW_DET_EN (sticky overflow detection).
//
// Ports:
//   wclk_i       write-domain clock
//   wrst_n_i     asynchronous active-low reset
//   winc_i       write request, accepted only while wfull_o = 0
//   wq2_rptr_i   synchronized Gray read pointer (ADDRSIZE+1 bits)
//   wovf_clr_i   clears woverflow_o (unused without the macro)
//   waddr_o      RAM write address
//   wptr_o       registered Gray write pointer
//   wfull_o      registered full flag
//   awfull_o     registered almost-full flag
//   wlevel_o     registered fill level seen from the write side
//   woverflow_o  sticky overflow flag
module wptr_full_ctrl #(
  parameter int ADDRSIZE      = 4,
  parameter int AWFULL_THRESH = 15
) (
  input  logic                wclk_i,
  input  logic                wrst_n_i,
  input  logic                winc_i,
  input  logic [ADDRSIZE:0]   wq2_rptr_i,
  input  logic                wovf_clr_i,
  output logic [ADDRSIZE-1:0] waddr_o,
  output logic [ADDRSIZE:0]   wptr_o,
  output logic                wfull_o,
  output logic                awfull_o,
  output logic [ADDRSIZE:0]   wlevel_o,
  output logic                woverflow_o
);

  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AWFULL_THRESH);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wgray_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic [ADDRSIZE:0] rbin;
  logic              wfull_q, wfull_d;
  logic              awfull_q, awfull_d;
  logic              wen;

  assign wen     = winc_i & ~wfull_q;
  assign wbin_d  = wbin_q + {{ADDRSIZE{1'b0}}, wen};
  assign wgray_d = (wbin_d >> 1) ^ wbin_d;

  // Gray-to-binary of the synchronized read pointer, MSB first.
  always_comb begin
    rbin           = '0;
    rbin[ADDRSIZE] = wq2_rptr_i[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ wq2_rptr_i[i];
    end
  end

  // Full when the next write pointer has lapped the read pointer exactly once:
  // in Gray code that means the two MSBs differ and the rest match.
  assign wfull_d  = (wgray_d == {~wq2_rptr_i[ADDRSIZE:ADDRSIZE-1], wq2_rptr_i[ADDRSIZE-2:0]});
  assign wlevel_d = wbin_d - rbin;
  assign awfull_d = (wlevel_d >= THRESH);

  // Pointer group
  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      wbin_q <= '0;
      wptr_q <= '0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wgray_d;
    end
  end

  // Status group
  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wlevel_q <= '0;
    end else begin
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
      wlevel_q <= wlevel_d;
    end
  end

`ifdef WFULL_OVERFLOW_DET_EN
  logic woverflow_q;

  // A dropped write sets the flag; set has priority over a same-edge clear.
  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      woverflow_q <= 1'b0;
    end else if (winc_i && wfull_q) begin
      woverflow_q <= 1'b1;
    end else if (wovf_clr_i) begin
      woverflow_q <= 1'b0;
    end
  end

  assign woverflow_o = woverflow_q;
`else
  logic unused_wovf_clr;
  assign unused_wovf_clr = wovf_clr_i;
  assign woverflow_o     = 1'b0;
`endif

  assign waddr_o  = wbin_q[ADDRSIZE-1:0];
  assign wptr_o   = wptr_q;
  assign wfull_o  = wfull_q;
  assign awfull_o = awfull_q;
  assign wlevel_o = wlevel_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// tb/tb_wptr_full_ctrl.sv - self-checking bench for wptr_full_ctrl
module tb_wptr_full_ctrl;

  localparam int DEPTH  = 16;
  localparam int THRESH = 15;
`ifdef WFULL_OVERFLOW_DET_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic       wclk_i = 1'b0;
  logic       wrst_n_i;
  logic       winc_i;
  logic [4:0] wq2_rptr_i;
  logic       wovf_clr_i;
  logic [3:0] waddr_o;
  logic [4:0] wptr_o;
  logic       wfull_o;
  logic       awfull_o;
  logic [4:0] wlevel_o;
  logic       woverflow_o;

  wptr_full_ctrl #(.ADDRSIZE(4), .AWFULL_THRESH(THRESH)) dut (
    .wclk_i      (wclk_i),
    .wrst_n_i    (wrst_n_i),
    .winc_i      (winc_i),
    .wq2_rptr_i  (wq2_rptr_i),
    .wovf_clr_i  (wovf_clr_i),
    .waddr_o     (waddr_o),
    .wptr_o      (wptr_o),
    .wfull_o     (wfull_o),
    .awfull_o    (awfull_o),
    .wlevel_o    (wlevel_o),
    .woverflow_o (woverflow_o)
  );

  always #5 wclk_i = ~wclk_i;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model: plain counts of accepted writes and of reads seen.
  int m_wr, m_rd;
  bit m_full, m_ovf;

  typedef struct {
    bit         winc;
    bit         clr;
    logic [4:0] rptr;
    int         waddr;
    int         wptr;
    bit         full;
    bit         awfull;
    int         level;
    bit         ovf;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [4:0] gray(input int n);
    logic [4:0] b;
    b = 5'(n % 32);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".waddr"},  int'(waddr_o),     m_wr % DEPTH);
    chk({tag, ".wptr"},   int'(wptr_o),      int'(gray(m_wr)));
    chk({tag, ".level"},  int'(wlevel_o),    m_wr - m_rd);
    chk({tag, ".full"},   int'(wfull_o),     int'(m_full));
    chk({tag, ".awfull"}, int'(awfull_o),    int'((m_wr - m_rd) >= THRESH));
    chk({tag, ".ovf"},    int'(woverflow_o), int'(m_ovf));
  endtask

  // One clock: drive, take the edge, advance the model, sample 1 ns later.
  task automatic cycle(input bit winc, input bit clr, input int rd);
    bit acc;
    winc_i     = winc;
    wovf_clr_i = clr;
    wq2_rptr_i = gray(rd);
    @(posedge wclk_i);
    acc = winc && !m_full;
    if (OVF_EN) begin
      if (winc && m_full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
    if (acc) m_wr++;
    m_rd   = rd;
    m_full = (m_wr - m_rd) == DEPTH;
    #1;
  endtask

  task automatic do_reset();
    wrst_n_i   = 1'b0;
    winc_i     = 1'b0;
    wovf_clr_i = 1'b0;
    wq2_rptr_i = '0;
    repeat (2) @(posedge wclk_i);
    @(negedge wclk_i);
    wrst_n_i = 1'b1;
    m_wr = 0; m_rd = 0; m_full = 0; m_ovf = 0;
    @(posedge wclk_i);
    #1;
  endtask

  initial begin
    int w2, old, lim;
    // Fill, overflow, clear, release and simultaneous write+read.
    // Fields: winc, clr, rptr(Gray), waddr, wptr, full, awfull, level, ovf
    tbl[0]  = '{1, 0, 5'd0,  1,  1, 0, 0,  1, 0};
    tbl[1]  = '{1, 0, 5'd0,  2,  3, 0, 0,  2, 0};
    tbl[2]  = '{1, 0, 5'd0,  3,  2, 0, 0,  3, 0};
    tbl[3]  = '{1, 0, 5'd0,  4,  6, 0, 0,  4, 0};
    tbl[4]  = '{1, 0, 5'd0,  5,  7, 0, 0,  5, 0};
    tbl[5]  = '{1, 0, 5'd0,  6,  5, 0, 0,  6, 0};
    tbl[6]  = '{1, 0, 5'd0,  7,  4, 0, 0,  7, 0};
    tbl[7]  = '{1, 0, 5'd0,  8, 12, 0, 0,  8, 0};
    tbl[8]  = '{1, 0, 5'd0,  9, 13, 0, 0,  9, 0};
    tbl[9]  = '{1, 0, 5'd0, 10, 15, 0, 0, 10, 0};
    tbl[10] = '{1, 0, 5'd0, 11, 14, 0, 0, 11, 0};
    tbl[11] = '{1, 0, 5'd0, 12, 10, 0, 0, 12, 0};
    tbl[12] = '{1, 0, 5'd0, 13, 11, 0, 0, 13, 0};
    tbl[13] = '{1, 0, 5'd0, 14,  9, 0, 0, 14, 0};
    tbl[14] = '{1, 0, 5'd0, 15,  8, 0, 1, 15, 0};
    tbl[15] = '{1, 0, 5'd0,  0, 24, 1, 1, 16, 0};
    tbl[16] = '{1, 0, 5'd0,  0, 24, 1, 1, 16, 1};
    tbl[17] = '{1, 0, 5'd0,  0, 24, 1, 1, 16, 1};
    tbl[18] = '{1, 0, 5'd0,  0, 24, 1, 1, 16, 1};
    tbl[19] = '{0, 1, 5'd0,  0, 24, 1, 1, 16, 0};
    tbl[20] = '{0, 0, 5'd1,  0, 24, 0, 1, 15, 0};
    tbl[21] = '{0, 0, 5'd3,  0, 24, 0, 0, 14, 0};
    tbl[22] = '{1, 0, 5'd3,  1, 25, 0, 1, 15, 0};
    tbl[23] = '{1, 0, 5'd2,  2, 27, 0, 1, 15, 0};

    do_reset();
    chk("reset.waddr",  int'(waddr_o),     0);
    chk("reset.wptr",   int'(wptr_o),      0);
    chk("reset.full",   int'(wfull_o),     0);
    chk("reset.awfull", int'(awfull_o),    0);
    chk("reset.level",  int'(wlevel_o),    0);
    chk("reset.ovf",    int'(woverflow_o), 0);

    for (int i = 0; i < 24; i++) begin
      winc_i     = tbl[i].winc;
      wovf_clr_i = tbl[i].clr;
      wq2_rptr_i = tbl[i].rptr;
      @(posedge wclk_i);
      #1;
      chk($sformatf("vec%0d.waddr", i),  int'(waddr_o),     tbl[i].waddr);
      chk($sformatf("vec%0d.wptr", i),   int'(wptr_o),      tbl[i].wptr);
      chk($sformatf("vec%0d.full", i),   int'(wfull_o),     int'(tbl[i].full));
      chk($sformatf("vec%0d.awfull", i), int'(awfull_o),    int'(tbl[i].awfull));
      chk($sformatf("vec%0d.level", i),  int'(wlevel_o),    tbl[i].level);
      chk($sformatf("vec%0d.ovf", i),    int'(woverflow_o), int'(OVF_EN && tbl[i].ovf));
    end

    // Wrap: 40 writes with the read pointer trailing two edges behind.
    do_reset();
    w2 = 0;
    for (int k = 0; k < 40; k++) begin
      old = m_wr;
      cycle(1'b1, 1'b0, w2);
      w2 = old;
      check_model($sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d.nofull", k), int'(wfull_o), 0);
      chk($sformatf("wrap%0d.lvl_le3", k), int'(wlevel_o <= 5'd3), 1);
      if (m_wr == 16) chk("wrap.msb_after16", int'(wptr_o[4]), 1);
      if (m_wr == 32) chk("wrap.msb_after32", int'(wptr_o[4]), 0);
    end

    // Asynchronous reset in the middle of a clock period.
    winc_i = 1'b1;
    @(posedge wclk_i);
    #3;
    wrst_n_i = 1'b0;
    #1;
    chk("midrst.waddr",  int'(waddr_o),     0);
    chk("midrst.wptr",   int'(wptr_o),      0);
    chk("midrst.full",   int'(wfull_o),     0);
    chk("midrst.awfull", int'(awfull_o),    0);
    chk("midrst.level",  int'(wlevel_o),    0);
    chk("midrst.ovf",    int'(woverflow_o), 0);

    // Randomized traffic; the read count never passes the write count of two edges ago.
    do_reset();
    w2 = 0;
    for (int k = 0; k < 400; k++) begin
      old = m_wr;
      lim = w2 - m_rd;
      if (lim > 3) lim = 3;
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
            m_rd + (($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, lim))));
      w2 = old;
      check_model($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
